regfile_write_arbiter: RTL

Shares the register file's two write ports (port 1, port 2) among NUM_REQ write-back requesters such as the ALU, load unit and stack unit. Arbitration is round-robin with up to two grants per cycle. Two grants to the same register in one cycle are never issued. Outputs are registered and drive the register file's write enables and {addr[4:0],data[15:0]} write buses directly.

---
 rtl/regfile_write_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter sharing the register file's two write ports among
// NUM_REQ write-back requesters. Up to two grants per cycle; two grants to the
// same register in one cycle are never issued. Write enables and buses are
// registered and drive the register file directly.
//
// Optional build macro: REGWR_R0_DISCARD_EN
//   defined   -> requests to addr 0 are accepted but never written (r0 == 0)
//   undefined -> addr 0 is an ordinary register
//
// Handshake: requester k transfers in the cycle where iReqValid[k] &&
// oReqReady[k]. A requester keeps valid and data stable until it is granted.
// oReqReady is combinational from iReqValid, iReqData, iStall, iResetN and the
// round-robin pointer only; it never depends on this block's outputs.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16
) (
    input  logic                               iClock,
    input  logic                               iResetN,
    input  logic                               iStall,
    input  logic [NUM_REQ-1:0]                 iReqValid,
    input  logic [NUM_REQ*(ADDR_W+DATA_W)-1:0] iReqData,
    output logic [NUM_REQ-1:0]                 oReqReady,
    output logic                               oWritePort1,
    output logic [ADDR_W+DATA_W-1:0]           oRegWrite1,
    output logic                               oWritePort2,
    output logic [ADDR_W+DATA_W-1:0]           oRegWrite2,
    output logic                               oCollision,
    output logic [7:0]                         oDeferCount
);

    localparam int W  = ADDR_W + DATA_W;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Round-robin pointer: first requester index examined in the scan.
    logic [PW-1:0] rr_ptr;

    // Per-requester {addr,data} word and its address field.
    logic [W-1:0]      req_word [NUM_REQ];
    logic [ADDR_W-1:0] req_addr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = iReqData[g*W +: W];
        assign req_addr[g] = req_word[g][W-1 -: ADDR_W];
    end

    // (base + offs) modulo NUM_REQ, for offs in 0..NUM_REQ.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[PW-1:0];
    endfunction

    // Arbitration results for the current cycle (before stall gating).
    logic [NUM_REQ-1:0] grant;
    logic               a_found;
    logic               b_found;
    logic [W-1:0]       a_word;
    logic [W-1:0]       b_word;
    logic [ADDR_W-1:0]  a_addr;
    logic               defer;
    logic               any_grant;
    logic [PW-1:0]      last_idx;
    logic [PW-1:0]      scan_k;
    logic               cand;

    // Scan from rr_ptr: slot A is the first candidate, slot B the next one with
    // a different address; same-address candidates passed over before slot B is
    // found (or with no slot B at all) are deferrals.
    always_comb begin
        grant     = '0;
        a_found   = 1'b0;
        b_found   = 1'b0;
        a_word    = '0;
        b_word    = '0;
        a_addr    = '0;
        defer     = 1'b0;
        any_grant = 1'b0;
        last_idx  = rr_ptr;
        scan_k    = rr_ptr;
        cand      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_k = wrap_add(rr_ptr, i);
            cand   = iReqValid[scan_k];
`ifdef REGWR_R0_DISCARD_EN
            // r0 writes are accepted and dropped; they take no slot but still
            // count as the most recent grant for pointer advance.
            if (cand && (req_addr[scan_k] == '0)) begin
                grant[scan_k] = 1'b1;
                any_grant     = 1'b1;
                last_idx      = scan_k;
                cand          = 1'b0;
            end
`endif
            if (cand) begin
                if (!a_found) begin
                    a_found       = 1'b1;
                    a_word        = req_word[scan_k];
                    a_addr        = req_addr[scan_k];
                    grant[scan_k] = 1'b1;
                    any_grant     = 1'b1;
                    last_idx      = scan_k;
                end else if (!b_found) begin
                    if (req_addr[scan_k] != a_addr) begin
                        b_found       = 1'b1;
                        b_word        = req_word[scan_k];
                        grant[scan_k] = 1'b1;
                        last_idx      = scan_k;
                    end else begin
                        defer = 1'b1;
                    end
                end
            end
        end
    end

    // Stall or reset suppresses every grant, so no transfer is half-done.
    logic a_fire;
    logic b_fire;
    logic defer_fire;
    logic ptr_fire;

    // Stall/reset gating of grants, port enables, deferral and pointer advance.
    always_comb begin
        oReqReady  = (iStall || !iResetN) ? '0 : grant;
        a_fire     = a_found && !iStall;
        b_fire     = b_found && !iStall;
        defer_fire = defer && !iStall;
        ptr_fire   = any_grant && !iStall;
    end

    // Registered write ports, collision pulse, saturating deferral count and
    // round-robin pointer; an unused port keeps its previous bus value.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            oWritePort1 <= 1'b0;
            oRegWrite1  <= '0;
            oWritePort2 <= 1'b0;
            oRegWrite2  <= '0;
            oCollision  <= 1'b0;
            oDeferCount <= 8'd0;
            rr_ptr      <= '0;
        end else begin
            oWritePort1 <= a_fire;
            if (a_fire) oRegWrite1 <= a_word;
            oWritePort2 <= b_fire;
            if (b_fire) oRegWrite2 <= b_word;
            oCollision <= defer_fire;
            if (defer_fire && (oDeferCount != 8'hFF)) oDeferCount <= oDeferCount + 8'd1;
            if (ptr_fire) rr_ptr <= wrap_add(last_idx, 1);
        end
    end

endmodule
